// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with IDLE/RUN/EXPIRED control and optional auto-reload.
// CNT uses the same [7:4]/[3:0] digit layout as the BCD up-counter so both can share a display path.
module bcd_down_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD,
  input  logic [7:0] LD_VAL,
  input  logic       START,
  input  logic       STOP,
  input  logic       DEC,
  output logic [7:0] CNT,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt_nx, rld, rld_nx, cnt_dec;
  logic       done_nx, err_nx, ld_ok;

  assign ld_ok   = (LD_VAL[7:4] <= 4'd9) && (LD_VAL[3:0] <= 4'd9);
  // Borrow from the upper digit when the lower digit is already zero.
  assign cnt_dec = (CNT[3:0] == 4'd0) ? {CNT[7:4] - 4'd1, 4'd9}
                                      : {CNT[7:4], CNT[3:0] - 4'd1};

  // Priority LD > STOP > START > DEC; only the highest asserted input acts.
  always_comb begin
    state_nx = state;
    cnt_nx   = CNT;
    rld_nx   = rld;
    done_nx  = 1'b0;
    err_nx   = ERR;
    if (LD) begin
      if (ld_ok) begin
        cnt_nx   = LD_VAL;
        rld_nx   = LD_VAL;
        err_nx   = 1'b0;
        state_nx = IDLE;
      end else begin
        err_nx = 1'b1;
      end
    end else if (STOP) begin
      if (state == RUN) state_nx = IDLE;
    end else if (START) begin
      if (state == IDLE && CNT != 8'h00) state_nx = RUN;
    end else if (DEC && state == RUN) begin
      if (CNT == 8'h01) begin
        done_nx = 1'b1;
        // A zero preset can never restart, so it expires even with reload enabled.
        if (AUTO_RELOAD && rld != 8'h00) begin
          cnt_nx = rld;
        end else begin
          cnt_nx   = 8'h00;
          state_nx = EXPIRED;
        end
      end else begin
        cnt_nx = cnt_dec;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      CNT     <= 8'h00;
      rld     <= 8'h00;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state   <= state_nx;
      CNT     <= cnt_nx;
      rld     <= rld_nx;
      RUNNING <= (state_nx == RUN);
      DONE    <= done_nx;
      ERR     <= err_nx;
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: vector table, hand sequences and random stimulus vs. a decimal model.
module tb_bcd_down_timer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LD = 1'b0, START = 1'b0, STOP = 1'b0, DEC = 1'b0;
  logic [7:0] LD_VAL = 8'h00;
  logic [7:0] cnt0, cnt1;
  logic       run0, run1, done0, done1, err0, err1;

  always #5 CLK = ~CLK;

  bcd_down_timer #(.AUTO_RELOAD(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .LD(LD), .LD_VAL(LD_VAL), .START(START), .STOP(STOP), .DEC(DEC),
    .CNT(cnt0), .RUNNING(run0), .DONE(done0), .ERR(err0));
  bcd_down_timer #(.AUTO_RELOAD(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .LD(LD), .LD_VAL(LD_VAL), .START(START), .STOP(STOP), .DEC(DEC),
    .CNT(cnt1), .RUNNING(run1), .DONE(done1), .ERR(err1));

  // Reference model works on the count as a plain decimal integer.
  typedef struct {
    int cnt; int rld; bit run; bit expd; bit done; bit err;
  } mdl_t;

  typedef struct {
    bit ld; logic [7:0] v; bit st; bit sp; bit dc;
    logic [7:0] cnt; bit run; bit done; bit err;
  } vec_t;

  mdl_t m0, m1;
  vec_t vecs[$];
  int   n_tests = 0, n_fail = 0;

  function automatic logic [7:0] to_bcd(int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit ar, bit ld, logic [7:0] v, bit st, bit sp, bit dc);
    mdl_t n = m;
    int   hi = int'(v[7:4]);
    int   lo = int'(v[3:0]);
    n.done = 1'b0;
    if (ld) begin
      if (hi <= 9 && lo <= 9) begin
        n.cnt = hi * 10 + lo; n.rld = n.cnt; n.err = 1'b0; n.run = 1'b0; n.expd = 1'b0;
      end else n.err = 1'b1;
    end else if (sp) begin
      n.run = 1'b0;
    end else if (st) begin
      if (!m.run && !m.expd && m.cnt != 0) n.run = 1'b1;
    end else if (dc && m.run) begin
      if (m.cnt > 1) n.cnt = m.cnt - 1;
      else begin
        n.done = 1'b1;
        if (ar && m.rld != 0) n.cnt = m.rld;
        else begin n.cnt = 0; n.run = 1'b0; n.expd = 1'b1; end
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_models(string tag);
    chk({tag, " d0 cnt"},  32'(cnt0),  32'(to_bcd(m0.cnt)));
    chk({tag, " d0 run"},  32'(run0),  32'(m0.run));
    chk({tag, " d0 done"}, 32'(done0), 32'(m0.done));
    chk({tag, " d0 err"},  32'(err0),  32'(m0.err));
    chk({tag, " d1 cnt"},  32'(cnt1),  32'(to_bcd(m1.cnt)));
    chk({tag, " d1 run"},  32'(run1),  32'(m1.run));
    chk({tag, " d1 done"}, 32'(done1), 32'(m1.done));
    chk({tag, " d1 err"},  32'(err1),  32'(m1.err));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " cnt"},  32'({cnt0, cnt1}), 32'h0);
    chk({tag, " flags"}, 32'({run0, done0, err0, run1, done1, err1}), 32'h0);
  endtask

  // Inputs change 1 time unit after an edge; one call = one clock edge.
  task automatic cyc(string tag, bit ld, logic [7:0] v, bit st, bit sp, bit dc);
    LD = ld; LD_VAL = v; START = st; STOP = sp; DEC = dc;
    @(posedge CLK);
    m0 = mstep(m0, 1'b0, ld, v, st, sp, dc);
    m1 = mstep(m1, 1'b1, ld, v, st, sp, dc);
    #1;
    chk_models(tag);
  endtask

  function automatic void add(bit ld, logic [7:0] v, bit st, bit sp, bit dc,
                              logic [7:0] cnt, bit run, bit done, bit err);
    vec_t e;
    e.ld = ld; e.v = v; e.st = st; e.sp = sp; e.dc = dc;
    e.cnt = cnt; e.run = run; e.done = done; e.err = err;
    vecs.push_back(e);
  endfunction

  initial begin
    // Expectations for the non-reloading instance.
    add(1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'h12, 1, 0, 0);          // DEC with START not counted
    for (int i = 0; i < 11; i++) add(0, 8'h00, 0, 0, 1, to_bcd(11 - i), 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 0);          // terminal decrement
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);          // EXPIRED ignores START
    add(1, 8'h30, 0, 0, 0, 8'h30, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h30, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h29, 1, 0, 0);
    add(0, 8'h00, 0, 1, 1, 8'h29, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h29, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h29, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h28, 1, 0, 0);
    add(1, 8'h1A, 0, 0, 1, 8'h28, 1, 0, 1);          // invalid load keeps state
    add(1, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0);
    add(1, 8'h40, 0, 0, 0, 8'h40, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h40, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h39, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);          // START on 00 ignored
    add(1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h01, 1, 0, 0);
    add(1, 8'h07, 0, 0, 1, 8'h07, 0, 0, 0);          // load beats terminal DEC
    add(1, 8'hA3, 0, 0, 0, 8'h07, 0, 0, 1);

    m0 = '{default: 0};
    m1 = '{default: 0};
    repeat (2) @(posedge CLK);
    #1;
    chk_zero("reset");
    RST = 1'b0;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cyc(t, vecs[i].ld, vecs[i].v, vecs[i].st, vecs[i].sp, vecs[i].dc);
      chk({t, " cnt"},  32'(cnt0),  32'(vecs[i].cnt));
      chk({t, " run"},  32'(run0),  32'(vecs[i].run));
      chk({t, " done"}, 32'(done0), 32'(vecs[i].done));
      chk({t, " err"},  32'(err0),  32'(vecs[i].err));
    end

    // Auto-reload: 02 -> 01,02,01,02,01 with DONE on the reload edges.
    cyc("ar ld", 1, 8'h02, 0, 0, 0);
    cyc("ar st", 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      string t;
      t = $sformatf("ar dec%0d", i);
      cyc(t, 0, 8'h00, 0, 0, 1);
      chk({t, " cnt"},  32'(cnt1),  (i % 2 == 0) ? 32'h01 : 32'h02);
      chk({t, " done"}, 32'(done1), 32'(i % 2 == 1));
      chk({t, " run"},  32'(run1),  32'h1);
    end

    // 99 down 50 ticks, then asynchronous reset in mid-cycle.
    cyc("r ld", 1, 8'h99, 0, 0, 0);
    cyc("r st", 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 50; i++) cyc("r dec", 0, 8'h00, 0, 0, 1);
    chk("r cnt49", 32'(cnt0), 32'h49);
    #3 RST = 1'b1;
    #1 chk_zero("async rst");
    @(posedge CLK);
    #1 chk_zero("rst held");
    RST = 1'b0;
    m0 = '{default: 0};
    m1 = '{default: 0};
    cyc("post rst start", 0, 8'h00, 1, 0, 0);
    chk("post rst run", 32'({run0, run1}), 32'h0);

    // Random traffic; small presets so expiry and reload occur often.
    for (int i = 0; i < 3000; i++) begin
      bit         ld, st, sp, dc;
      logic [7:0] v;
      ld = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 11) == 0);
      dc = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) v = 8'($urandom_range(0, 255));
      else v = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      cyc($sformatf("rnd%0d", i), ld, v, st, sp, dc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
